// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing, captured-image geometry and sync polarity for the VGA scan-out path.
package vga_pkg;

    localparam int unsigned HVisible = 640;
    localparam int unsigned HFront   = 16;
    localparam int unsigned HSync    = 96;
    localparam int unsigned HBack    = 48;
    localparam int unsigned HTotal   = HVisible + HFront + HSync + HBack;

    localparam int unsigned VVisible = 480;
    localparam int unsigned VFront   = 10;
    localparam int unsigned VSync    = 2;
    localparam int unsigned VBack    = 33;
    localparam int unsigned VTotal   = VVisible + VFront + VSync + VBack;

    localparam int unsigned FbAddrWidth = 14;
    localparam int unsigned FbDataWidth = 8;
    localparam int unsigned ImgW        = 512;
    localparam int unsigned ImgH        = 256;
    localparam int unsigned XOff        = 64;
    localparam int unsigned YOff        = 112;

    localparam bit SyncPol = 1'b0;

    // Control signals carried down the two-stage alignment pipeline.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic fs;
    } vga_ctrl_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus hsync/vsync/de/frame_start, delayed two clocks to line up with pixel data.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = HVisible,
    parameter int unsigned H_FRONT   = HFront,
    parameter int unsigned H_SYNC    = HSync,
    parameter int unsigned H_BACK    = HBack,
    parameter int unsigned V_VISIBLE = VVisible,
    parameter int unsigned V_FRONT   = VFront,
    parameter int unsigned V_SYNC    = VSync,
    parameter int unsigned V_BACK    = VBack,
    parameter bit          SYNC_POL  = SyncPol,
    localparam int unsigned HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    localparam int unsigned VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          de_s1_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          frame_start_o
);

    localparam logic [HW-1:0] HMax    = HW'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [HW-1:0] HVis    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HsStart = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HsEnd   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VMax    = VW'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [VW-1:0] VVis    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VsStart = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VsEnd   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam vga_ctrl_t CtrlRst = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0, fs: 1'b0};

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    vga_ctrl_t     ctrl_s0, ctrl_s1_q, ctrl_s2_q;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HMax) begin
            h_d = '0;
            v_d = (v_q == VMax) ? '0 : v_q + 1'b1;
        end

        ctrl_s0.hsync = (h_q >= HsStart && h_q < HsEnd) ? SYNC_POL : ~SYNC_POL;
        ctrl_s0.vsync = (v_q >= VsStart && v_q < VsEnd) ? SYNC_POL : ~SYNC_POL;
        ctrl_s0.de    = (h_q < HVis) && (v_q < VVis);
        ctrl_s0.fs    = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q       <= '0;
            v_q       <= '0;
            ctrl_s1_q <= CtrlRst;
            ctrl_s2_q <= CtrlRst;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            ctrl_s1_q <= ctrl_s0;
            ctrl_s2_q <= ctrl_s1_q;
        end
    end

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign de_s1_o       = ctrl_s1_q.de;
    assign hsync_o       = ctrl_s2_q.hsync;
    assign vsync_o       = ctrl_s2_q.vsync;
    assign de_o          = ctrl_s2_q.de;
    assign frame_start_o = ctrl_s2_q.fs;

endmodule

// File: rtl/vga_fb_reader.sv
// Scans the frame buffer out as VGA: address generation, byte-to-pixel unpack, output alignment.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FbAddrWidth,
    parameter int unsigned DATA_WIDTH = FbDataWidth,
    parameter int unsigned H_VISIBLE  = HVisible,
    parameter int unsigned H_FRONT    = HFront,
    parameter int unsigned H_SYNC     = HSync,
    parameter int unsigned H_BACK     = HBack,
    parameter int unsigned V_VISIBLE  = VVisible,
    parameter int unsigned V_FRONT    = VFront,
    parameter int unsigned V_SYNC     = VSync,
    parameter int unsigned V_BACK     = VBack,
    parameter int unsigned IMG_W      = ImgW,
    parameter int unsigned IMG_H      = ImgH,
    parameter int unsigned X_OFF      = XOff,
    parameter int unsigned Y_OFF      = YOff,
    parameter bit          SYNC_POL   = SyncPol
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  pixel,
    output logic                  frame_start
);

    localparam int unsigned HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam int unsigned VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam int unsigned PB = $clog2(DATA_WIDTH);
    localparam int unsigned XB = $clog2(IMG_W / DATA_WIDTH);
    localparam int unsigned YB = ADDR_WIDTH - XB;

    localparam logic [HW-1:0] XLo = HW'(X_OFF);
    localparam logic [HW-1:0] XHi = HW'(X_OFF + IMG_W);
    localparam logic [VW-1:0] YLo = VW'(Y_OFF);
    localparam logic [VW-1:0] YHi = VW'(Y_OFF + IMG_H);

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic                  de_s1;
    logic                  in_img;
    logic [PB+XB-1:0]      x_lo;
    logic [YB-1:0]         y_lo;
    logic                  in_img_q;
    logic [PB-1:0]         xpix_q;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  pix_s1;
    logic                  pixel_q, pixel_d;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_VISIBLE(V_VISIBLE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_i        (clk),
        .rst_i        (reset),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .de_s1_o      (de_s1),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .de_o         (de),
        .frame_start_o(frame_start)
    );

    // Stage 0: address straight from the counter registers so the RAM sees a clean path.
    always_comb begin
        in_img = (h_cnt >= XLo) && (h_cnt < XHi) && (v_cnt >= YLo) && (v_cnt < YHi);
        x_lo   = (PB + XB)'(h_cnt - XLo);
        y_lo   = YB'(v_cnt - YLo);
        raddr  = in_img ? {y_lo, x_lo[PB+XB-1:PB]} : '0;
    end

    // Stage 1: first pixel of a byte comes straight off rdata, the rest from the hold copy.
    always_comb begin
        hold_d = hold_q;
        pix_s1 = 1'b0;
        if (in_img_q) begin
            if (xpix_q == '0) begin
                hold_d = rdata;
                pix_s1 = rdata[DATA_WIDTH-1];
            end else begin
                pix_s1 = hold_q[PB'(DATA_WIDTH - 1) - xpix_q];
            end
        end
        pixel_d = pix_s1 & de_s1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_img_q <= 1'b0;
            xpix_q   <= '0;
            hold_q   <= '0;
            pixel_q  <= 1'b0;
        end else begin
            in_img_q <= in_img;
            xpix_q   <= x_lo[PB-1:0];
            hold_q   <= hold_d;
            pixel_q  <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader on a scaled raster (80x30 total, 32x8 image at 16,8) for short frames.
module tb_vga_fb_reader;

    localparam int HT = 80;
    localparam int VT = 30;
    localparam int HV = 64;
    localparam int VV = 24;
    localparam int HS0 = 68;
    localparam int HS1 = 76;
    localparam int VS0 = 26;
    localparam int VS1 = 28;
    localparam int XO = 16;
    localparam int YO = 8;
    localparam int IW = 32;
    localparam int IH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] raddr;
    logic [7:0] rdata = 8'h00;
    logic       hsync, vsync, de, pixel, frame_start;

    logic [7:0] mem [32];

    int   n_checks = 0;
    int   n_errors = 0;
    int   n = 0;
    int   phase = 0;
    int   last_hs_fall, last_vs_fall, de_cnt, pix_cnt;
    logic prev_hs, prev_vs;
    bit   frame_seen, mem_ff;
    logic [7:0] seq;

    vga_fb_reader #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(8),
        .H_VISIBLE (64),
        .H_FRONT   (4),
        .H_SYNC    (8),
        .H_BACK    (4),
        .V_VISIBLE (24),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (2),
        .IMG_W     (32),
        .IMG_H     (8),
        .X_OFF     (16),
        .Y_OFF     (8),
        .SYNC_POL  (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .rdata      (rdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .pixel      (pixel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // One-clock-latency synchronous RAM read port.
    always @(posedge clk) rdata <= mem[raddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int pos);
        int h, v;
        h = pos % HT;
        v = (pos / HT) % VT;
        if (h >= XO && h < XO + IW && v >= YO && v < YO + IH)
            return (v - YO) * (IW / 8) + (h - XO) / 8;
        return 0;
    endfunction

    // Expected {hsync, vsync, de, frame_start, pixel} for counter index idx.
    function automatic logic [4:0] exp_out(input int idx);
        int h, v;
        logic hs, vs, d, fs, px;
        logic [7:0] b;
        if (idx < 0) return 5'b11000;
        h  = idx % HT;
        v  = (idx / HT) % VT;
        hs = (h >= HS0 && h < HS1) ? 1'b0 : 1'b1;
        vs = (v >= VS0 && v < VS1) ? 1'b0 : 1'b1;
        d  = (h < HV) && (v < VV);
        fs = (h == 0) && (v == 0);
        px = 1'b0;
        if (h >= XO && h < XO + IW && v >= YO && v < YO + IH) begin
            b  = mem[exp_addr(idx)];
            px = b[7 - ((h - XO) % 8)];
        end
        return {hs, vs, d, fs, px & d};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        last_hs_fall = -1;
        last_vs_fall = -1;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        de_cnt = 0;
        pix_cnt = 0;
        frame_seen = 1'b0;
        check_eq("reset_outputs", {hsync, vsync, de, frame_start, pixel}, 5'b11000);
        check_eq("reset_raddr", raddr, 0);
    endtask

    task automatic run_to(input int upto);
        while (n < upto) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_eq("outputs", {hsync, vsync, de, frame_start, pixel}, exp_out(n - 2));
            check_eq("raddr", raddr, exp_addr(n));

            if (prev_hs && !hsync) begin
                if (last_hs_fall >= 0) check_eq("hsync_period", n - last_hs_fall, HT);
                last_hs_fall = n;
            end
            if (!prev_hs && hsync && last_hs_fall >= 0)
                check_eq("hsync_low", n - last_hs_fall, HS1 - HS0);
            if (prev_vs && !vsync) begin
                if (last_vs_fall >= 0) check_eq("vsync_period", n - last_vs_fall, HT * VT);
                last_vs_fall = n;
            end
            if (!prev_vs && vsync && last_vs_fall >= 0)
                check_eq("vsync_low", n - last_vs_fall, (VS1 - VS0) * HT);
            prev_hs = hsync;
            prev_vs = vsync;

            if (frame_start) begin
                check_eq("fs_with_de", de, 1);
                if (frame_seen) begin
                    check_eq("de_per_frame", de_cnt, HV * VV);
                    if (mem_ff) check_eq("lit_per_frame", pix_cnt, IW * IH);
                end
                frame_seen = 1'b1;
                de_cnt = 0;
                pix_cnt = 0;
            end
            de_cnt += int'(de);
            pix_cnt += int'(pixel);

            if (phase == 0) begin
                if (n == 656) check_eq("origin_raddr", raddr, 0);
                if (n >= 658 && n <= 665) seq = {seq[6:0], pixel};
                if (n == 665) check_eq("origin_byte_seq", seq, 8'hA5);
                if (n == 1247) check_eq("last_raddr", raddr, 31);
                if (n == 1248) check_eq("past_img_raddr", raddr, 0);
                if (n == 1249) check_eq("last_pixel", pixel, 1);
                if (n == 1250) check_eq("past_img_pixel", pixel, 0);
            end
        end
    endtask

    initial begin
        seq = 8'h00;
        // Sparse image: A5 at the top-left byte, 01 at the bottom-right byte.
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'hA5;
        mem[31] = 8'h01;
        mem_ff  = 1'b0;
        phase   = 0;
        do_reset();
        run_to(5000);

        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        mem_ff = 1'b1;
        phase  = 1;
        do_reset();
        // Counter position 3230 is line 10, h=30: mid-line inside the image window.
        run_to(3230);
        check_eq("pre_reset_pixel", pixel, 1);
        check_eq("pre_reset_raddr", raddr, 9);
        reset = 1'b1;
        #1;
        check_eq("async_reset_outputs", {hsync, vsync, de, frame_start, pixel}, 5'b11000);
        check_eq("async_reset_raddr", raddr, 0);

        phase = 2;
        do_reset();
        run_to(2500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
